ifetch_prefetch_buffer: RTL

Instruction prefetch unit sitting directly upstream of the pipelined core's IF/ID register. It issues sequential word fetches to an instruction memory with a valid/ready request channel and in-order, variable-latency responses. Returned instructions are buffered in a small queue, then presented to the core with a valid/ready handshake. A redirect (taken branch or jump resolved in EX) flushes the queue and discards stale in-flight responses.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/sync_fifo_flush.sv | 64 ++++++
 rtl/ifetch_prefetch_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core types and constants.
// Fetch-side bundles used by the prefetch buffer.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] ILEN_BYTES = 32'd4;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t align_pc(word_t pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with flush and occupancy count.
// Head data is visible combinationally; flush beats push/pop.
module sync_fifo_flush #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full, empty;
  logic do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop_i && !empty && !flush_i;
  assign do_push = push_i && (!full || do_pop) && !flush_i;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop) rd_d = rd_q + AW'(1);
      if (do_push) wr_d = wr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_prefetch_buffer.sv
// Sequential instruction prefetcher feeding the IF/ID register.
// Credit-limited requests, in-order responses, redirect flush.
module ifetch_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  word_t fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] q_cnt, tag_cnt;
  logic [CW:0] credit;
  fetch_entry_t q_head, q_wdata;
  word_t tag_head;
  logic req_fire, rsp_ok, rsp_keep, pop, q_nonempty;

  assign credit = {1'b0, q_cnt} + {1'b0, inflight_q};
  assign q_nonempty = (q_cnt != '0);

  assign imem_req_valid = rst && !redirect_valid
                       && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;

  // Responses with no outstanding request are ignored entirely.
  assign rsp_ok   = imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep = rsp_ok && (stale_q == '0) && !redirect_valid;

  assign fetch_valid = rst && q_nonempty && !redirect_valid;
  assign fetch_instr = q_nonempty ? q_head.instr : '0;
  assign fetch_pc    = q_nonempty ? q_head.pc : '0;
  assign pop = fetch_valid && fetch_ready;

  assign q_wdata = '{pc: tag_head, instr: imem_rsp_data};

  sync_fifo_flush #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_instr_q (
    .clk_i  (clk),
    .rst_ni (rst),
    .flush_i(redirect_valid),
    .push_i (rsp_keep),
    .data_i (q_wdata),
    .pop_i  (pop),
    .head_o (q_head),
    .count_o(q_cnt)
  );

  sync_fifo_flush #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_tag_q (
    .clk_i  (clk),
    .rst_ni (rst),
    .flush_i(redirect_valid),
    .push_i (req_fire),
    .data_i (fetch_pc_q),
    .pop_i  (rsp_keep),
    .head_o (tag_head),
    .count_o(tag_cnt)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    if (redirect_valid) begin
      // Everything still outstanding becomes stale.
      inflight_d = inflight_q - CW'(rsp_ok);
      stale_d    = inflight_q - CW'(rsp_ok);
      fetch_pc_d = align_pc(redirect_pc);
    end else begin
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && (stale_q != '0)) stale_d = stale_q - CW'(1);
      if (req_fire) fetch_pc_d = fetch_pc_q + ILEN_BYTES;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      stale_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end

  a_rsp_credit: assert property (
    @(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (inflight_q == '0)));

  a_tag_track: assert property (
    @(posedge clk) disable iff (!rst)
    tag_cnt == (inflight_q - stale_q));

endmodule
